// File: rtl/stream_sink_checker_if.sv
// Valid/ready word stream carrying layer-pipeline output into the sink checker.
// The producer drives data/valid through master; the sink answers with ready through slave.
interface stream_sink_checker_if #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0] s_data_in_y;
    logic                    s_valid_y;
    logic                    s_ready_y;

    modport master (output s_data_in_y, output s_valid_y, input s_ready_y);
    modport slave  (input s_data_in_y, input s_valid_y, output s_ready_y);
endinterface

// File: rtl/stream_sink_checker.sv
// Self-checking stream sink: compares NUMVALS words against a preloaded memory; one word per cycle max.
// Ready comes from registered state only; SINK_BACKPRESSURE_EN throttles it with a seeded LFSR.
module stream_sink_checker #(
    parameter int          WIDTH   = 16,
    parameter int          NUMVALS = 2340,
    parameter int          AW      = 12,
    parameter int          ERRW    = 16,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    exp_wr_en,
    input  logic [AW-1:0]           exp_wr_addr,
    input  logic signed [WIDTH-1:0] exp_wr_data,
    input  logic                    start,
    stream_sink_checker_if.slave    s_y,
    output logic                    busy,
    output logic                    done,
    output logic [ERRW-1:0]         errors,
    output logic                    first_err_valid,
    output logic [AW-1:0]           first_err_idx
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [ERRW-1:0]         errors_q, errors_d;
    logic                    fev_q, fev_d;
    logic [AW-1:0]           fei_q, fei_d;
    logic signed [WIDTH-1:0] mem_q [NUMVALS];

    logic gate;
    logic hs;
    logic mismatch;
    logic in_run;
    logic run_enter;

    assign in_run    = (state_q == ST_RUN);
    assign run_enter = !in_run && start;

`ifdef SINK_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1; steps every RUN cycle.
    always_comb begin
        lfsr_d = lfsr_q;
        if (run_enter) begin
            lfsr_d = SEED;
        end else if (in_run) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign gate = lfsr_q[0];
`else
    assign gate = 1'b1;
`endif

    assign s_y.s_ready_y = in_run & gate;
    assign hs            = in_run & s_y.s_valid_y & gate;
    assign mismatch      = (s_y.s_data_in_y != mem_q[idx_q]);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        errors_d = errors_q;
        fev_d    = fev_q;
        fei_d    = fei_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    idx_d    = '0;
                    errors_d = '0;
                    fev_d    = 1'b0;
                    fei_d    = '0;
                end
            end
            ST_RUN: begin
                if (hs) begin
                    if (mismatch) begin
                        if (errors_q != '1) begin
                            errors_d = errors_q + 1'b1;
                        end
                        if (!fev_q) begin
                            fev_d = 1'b1;
                            fei_d = idx_q;
                        end
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == AW'(NUMVALS - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            errors_q <= '0;
            fev_q    <= 1'b0;
            fei_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            errors_q <= errors_d;
            fev_q    <= fev_d;
            fei_q    <= fei_d;
        end
    end

    // Expected memory survives reset so a reloaded run needs no re-preload.
    always_ff @(posedge clk) begin
        if (exp_wr_en && !in_run && (int'(exp_wr_addr) < NUMVALS)) begin
            mem_q[exp_wr_addr] <= exp_wr_data;
        end
    end

    assign busy            = in_run;
    assign done            = (state_q == ST_DONE);
    assign errors          = errors_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fei_q;
endmodule

// File: doc/stream_sink_checker.md
# stream_sink_checker

Synthesizable self-checking sink for the layer-pipeline output stream. It sits on the `m_data_out_y`/`m_valid_y`/`m_ready_y` side of a multi-layer design and is the receiving end of that valid/ready handshake. It accepts a fixed count of words, compares each against a preloaded expected-value memory, and reports an error count, the first failing index and completion. It lets on-chip / FPGA runs reproduce the bench's pass/fail check without a simulator.

## Interface
- `WIDTH`, 16, data word width (signed)
- `NUMVALS`, 2340, words per run
- `AW`, 12, address/index width; `2**AW >= NUMVALS`
- `ERRW`, 16, error-counter width (saturating)
- `SEED`, 16'hACE1, LFSR seed; nonzero

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `exp_wr_en`  in  1  expected-memory write strobe
- `exp_wr_addr`  in  AW  expected-memory write address
- `exp_wr_data`  in  WIDTH  expected value
- `start`  in  1  begin a run (single-cycle pulse or level)
- `s_data_in_y`  in  WIDTH  stream data from DUT
- `s_valid_y`  in  1  stream valid from DUT
- `s_ready_y`  out  1  stream ready to DUT
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE
- `errors`  out  ERRW  mismatch count, saturates at all-ones
- `first_err_valid`  out  1  at least one mismatch this run
- `first_err_idx`  out  AW  index of first mismatch

## Operation
- States: IDLE, RUN, DONE. Reset (`reset`=0 at edge) forces IDLE and zeroes `idx`, `errors`, `first_err_valid`, `first_err_idx`, LFSR=`SEED`. All outputs are 0 in reset. Memory contents are not cleared.
- IDLE/DONE: `exp_wr_en`=1 writes `mem[exp_wr_addr]`. Writes in RUN are ignored. Addresses >= NUMVALS are ignored.
- IDLE or DONE with `start`=1 → RUN next cycle. Entering RUN clears `idx`, `errors`, `first_err_*`. `start` in RUN is ignored.
- RUN: `s_ready_y` = gate (see Configuration). Handshake = `s_valid_y & s_ready_y` at the rising edge.
- On a handshake, compare `s_data_in_y != mem[idx]`. Memory read is asynchronous on `idx`.
  - Mismatch: `errors` increments unless already all-ones.
  - First mismatch of the run: `first_err_valid`←1, `first_err_idx`←`idx`.
  - `idx` increments.
- Handshake with `idx == NUMVALS-1` → DONE. `s_ready_y` is 0 in DONE and IDLE. Results hold until the next start or reset.
- `s_ready_y` depends only on registered state and LFSR, never on `s_valid_y`. No combinational path from valid to ready.

## Timing
- `s_ready_y` may rise or fall any cycle in RUN. Data is sampled only on handshake cycles; data on other cycles is don't-care.
- `errors`/`first_err_*` update on the edge of the handshake and are visible the following cycle.
- `done` asserts the cycle after the final handshake, with `errors` already final. `busy` drops the same cycle.
- Back-to-back handshakes are supported at 1 word/cycle with gate held high.
- Reset mid-RUN aborts: IDLE next cycle, counters zeroed, no `done`.
- `start` and `exp_wr_en` in the same IDLE cycle: the write occurs and the run starts. Index 0 reads the new value if the addresses match.

## Configuration
- `SINK_BACKPRESSURE_EN` defined:
  - Gate = `lfsr[0]`. The LFSR is 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shifting every RUN cycle (whether or not a handshake occurs).
  - The LFSR is reloaded with `SEED` on entering RUN.
  - This emulates the bench's random `m_ready_y` throttling.
- Undefined: gate = 1 throughout RUN, no LFSR logic.

## Test plan
- NUMVALS=4, load {0x0001,0xFFFF,0x7FFF,0x8000}, start, stream the same with `s_valid_y` always 1, macro off → 4 consecutive handshakes; `done`=1 one cycle later; `errors`=0; `first_err_valid`=0.
- Same load, stream {0x0001,0xFFFF,0x1234,0x8001} → `errors`=2, `first_err_idx`=2, `first_err_valid`=1.
- Macro on, `s_valid_y` held 1:
  - `s_ready_y` equals `lfsr[0]` of the `SEED`-seeded sequence cycle by cycle.
  - No `idx` advance on ready-low cycles.
  - Final `errors`=0.
- Reset low for one cycle after 2 of 4 handshakes → IDLE, `busy`=0, `done`=0, `errors`=0. A new start completes a full 4-word run.
- ERRW=2, NUMVALS=4, all mismatching → `errors` saturates at 3; `first_err_idx`=0.
- `start` pulsed mid-RUN and `exp_wr_en` to addr 3 mid-RUN → run not restarted; mem[3] unchanged; compare uses the original value.
